branch_resolve_unit: RTL and testbench

- Parametrised successor to the EX-stage branch comparator of the 5-stage RISC-V core.
- Resolves all six B-type conditions at configurable XLEN with a correct signed/unsigned compare, computed by subtraction.
- Owns a PC-indexed branch history table (BHT) of 2-bit saturating counters that supplies IF-stage predictions.
- Trains the BHT on every resolved branch and issues a registered one-cycle redirect/flush pulse on misprediction; also keeps branch and mispredict counters.

---
 rtl/branch_resolve_unit_pkg.sv | 28 ++
 rtl/branch_resolve_unit_br_compare.sv | 49 ++++
 rtl/branch_resolve_unit.sv | 144 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_pkg
// Description : Shared constants for the EX-stage branch resolve unit:
//               B-type opcode, branch funct3 encodings, BHT reset value.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'h63;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly not-taken
  localparam logic [1:0] BHT_RESET = 2'b01;

  // funct3 010 and 011 have no branch meaning
  function automatic logic f3_is_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_br_compare.sv
`default_nettype none
// ============================================================================
// Module      : br_compare
// Description : Combinational XLEN-wide branch comparator. Derives eq/lt/ltu
//               from one XLEN+1 bit subtraction and selects the condition.
// Revision    : 1.0 - initial release
// ============================================================================
module br_compare
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            eq,
  output logic            lt,
  output logic            ltu,
  output logic            taken
);

  logic [XLEN:0] diff;
  logic          unused_diff;

  assign diff        = {1'b0, rs1} - {1'b0, rs2};
  assign unused_diff = &{1'b0, diff[XLEN-2:0]};

  assign eq  = (rs1 == rs2);
  // Borrow out of the zero-extended subtraction is the unsigned less-than
  assign ltu = diff[XLEN];
  // Differing signs decide directly; otherwise the difference sign is exact
  assign lt  = (rs1[XLEN-1] != rs2[XLEN-1]) ? rs1[XLEN-1] : diff[XLEN-1];

  // Condition mux over the six legal branch encodings
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : EX-stage branch resolution with a PC-indexed table of 2-bit
//               saturating counters, registered redirect on mispredict and
//               branch/mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_flush,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic             ex_pred_taken,
  output logic             br_taken,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [1:0]      bht_d [BHT_ENTRIES];

  logic            br_taken_q, br_taken_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            illegal_br_q, illegal_br_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  logic [IDX-1:0]  if_idx, ex_idx;
  logic            is_branch, res, illegal_ev;
  logic            cmp_eq, cmp_lt, cmp_ltu, actual;
  logic [XLEN-1:0] target;
  logic [1:0]      cur_ctr, nxt_ctr;
  logic            unused_pc_bits;

  assign if_idx         = if_pc[IDX+1:2];
  assign ex_idx         = ex_pc[IDX+1:2];
  assign unused_pc_bits = &{1'b0, if_pc, ex_pc[1:0]};

  // Lookup reads the registered table, so a same-cycle update is not visible
  assign if_pred_taken = bht_q[if_idx][1];

  assign is_branch  = ex_valid & ~ex_stall & ~ex_flush & (ex_opcode == OPC_BRANCH);
  assign res        = is_branch & f3_is_legal(ex_funct3);
  assign illegal_ev = is_branch & ~f3_is_legal(ex_funct3);

  br_compare #(.XLEN(XLEN)) u_cmp (
    .rs1    (ex_rs1),
    .rs2    (ex_rs2),
    .funct3 (ex_funct3),
    .eq     (cmp_eq),
    .lt     (cmp_lt),
    .ltu    (cmp_ltu),
    .taken  (actual)
  );

  assign target = actual ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));

  // Saturating counter step for the entry addressed by the EX PC
  always_comb begin
    cur_ctr = bht_q[ex_idx];
    nxt_ctr = cur_ctr;
    if (actual) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'd1;
    end
  end

  // Next-state for the table, result registers and statistics
  always_comb begin
    bht_d              = bht_q;
    br_taken_d         = br_taken_q;
    redirect_valid_d   = redirect_valid_q;
    redirect_pc_d      = redirect_pc_q;
    illegal_br_d       = illegal_br_q;
    br_count_d         = br_count_q;
    mispredict_count_d = mispredict_count_q;
    if (!ex_stall) begin
      redirect_valid_d = 1'b0;
      illegal_br_d     = illegal_ev;
      if (res) begin
        bht_d[ex_idx]    = nxt_ctr;
        br_taken_d       = actual;
        redirect_valid_d = (actual != ex_pred_taken);
        redirect_pc_d    = target;
        br_count_d       = br_count_q + CNT_W'(1);
        if (actual != ex_pred_taken)
          mispredict_count_d = mispredict_count_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset discards any resolution in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_RESET;
      br_taken_q         <= 1'b0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      illegal_br_q       <= 1'b0;
      br_count_q         <= '0;
      mispredict_count_q <= '0;
    end else begin
      bht_q              <= bht_d;
      br_taken_q         <= br_taken_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      illegal_br_q       <= illegal_br_d;
      br_count_q         <= br_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign br_taken         = br_taken_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign illegal_br       = illegal_br_q;
  assign br_count         = br_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_stall, ex_flush;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2;
  logic        ex_pred_taken;
  logic        br_taken, redirect_valid, illegal_br;
  logic [31:0] redirect_pc, br_count, mispredict_count;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .ex_valid         (ex_valid),
    .ex_stall         (ex_stall),
    .ex_flush         (ex_flush),
    .ex_opcode        (ex_opcode),
    .ex_funct3        (ex_funct3),
    .ex_pc            (ex_pc),
    .ex_imm           (ex_imm),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .ex_pred_taken    (ex_pred_taken),
    .br_taken         (br_taken),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .illegal_br       (illegal_br),
    .br_count         (br_count),
    .mispredict_count (mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b, input logic pred);
    ex_valid      = 1'b1;
    ex_opcode     = 7'h63;
    ex_funct3     = f3;
    ex_pc         = pc;
    ex_imm        = imm;
    ex_rs1        = a;
    ex_rs2        = b;
    ex_pred_taken = pred;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    ex_stall = 1'b0;
    ex_flush = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic rv, input logic [31:0] rpc,
                         input logic tk, input logic [31:0] bc, input logic [31:0] mc);
    chk({tag, ".rv"}, {31'd0, redirect_valid}, {31'd0, rv});
    chk({tag, ".rpc"}, redirect_pc, rpc);
    chk({tag, ".tk"}, {31'd0, br_taken}, {31'd0, tk});
    chk({tag, ".bc"}, br_count, bc);
    chk({tag, ".mc"}, mispredict_count, mc);
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h100; idle();
    ex_opcode = 7'h00; ex_funct3 = 3'd0; ex_pc = '0; ex_imm = '0;
    ex_rs1 = '0; ex_rs2 = '0; ex_pred_taken = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset.pred", {31'd0, if_pred_taken}, 32'd0);
    chk("reset.ill", {31'd0, illegal_br}, 32'd0);
    chk_res("reset", 1'b0, 32'h0, 1'b0, 32'd0, 32'd0);

    // BEQ taken, predicted not taken
    drive(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0); tick(); idle();
    chk_res("beq", 1'b1, 32'h120, 1'b1, 32'd1, 32'd1);
    chk("beq.pred", {31'd0, if_pred_taken}, 32'd1);
    tick();
    chk_res("beq.after", 1'b0, 32'h120, 1'b1, 32'd1, 32'd1);

    // Signed versus unsigned
    drive(3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1); tick(); idle();
    chk_res("blt", 1'b0, 32'h240, 1'b1, 32'd2, 32'd1);
    drive(3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1); tick(); idle();
    chk_res("bltu", 1'b1, 32'h204, 1'b0, 32'd3, 32'd2);
    drive(3'b101, 32'h300, 32'h10, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0); tick(); idle();
    chk_res("bge", 1'b0, 32'h304, 1'b0, 32'd4, 32'd2);

    // Training at 0x40
    if_pc = 32'h40;
    drive(3'b001, 32'h40, 32'h8, 32'd1, 32'd2, 1'b0); tick();
    chk_res("tr1", 1'b1, 32'h48, 1'b1, 32'd5, 32'd3);
    chk("tr1.pred", {31'd0, if_pred_taken}, 32'd1);
    drive(3'b001, 32'h40, 32'h8, 32'd1, 32'd2, 1'b1); tick();
    chk_res("tr2", 1'b0, 32'h48, 1'b1, 32'd6, 32'd3);
    drive(3'b001, 32'h40, 32'h8, 32'd1, 32'd2, 1'b1); tick();
    chk_res("tr3", 1'b0, 32'h48, 1'b1, 32'd7, 32'd3);
    chk("tr3.pred", {31'd0, if_pred_taken}, 32'd1);
    drive(3'b001, 32'h40, 32'h8, 32'd3, 32'd3, 1'b1); tick();
    chk_res("tr4", 1'b1, 32'h44, 1'b0, 32'd8, 32'd4);
    chk("tr4.pred", {31'd0, if_pred_taken}, 32'd1);
    drive(3'b001, 32'h40, 32'h8, 32'd3, 32'd3, 1'b1); tick(); idle();
    chk_res("tr5", 1'b1, 32'h44, 1'b0, 32'd9, 32'd5);
    chk("tr5.pred", {31'd0, if_pred_taken}, 32'd0);
    tick();
    chk("tr5.clear", {31'd0, redirect_valid}, 32'd0);

    // Stalled branch has no effect
    drive(3'b000, 32'h500, 32'h100, 32'd7, 32'd7, 1'b0); ex_stall = 1'b1; tick(); idle();
    chk_res("stall", 1'b0, 32'h44, 1'b0, 32'd9, 32'd5);
    // Pending redirect held through a stall
    drive(3'b000, 32'h500, 32'h100, 32'd7, 32'd7, 1'b0); tick();
    chk_res("pend", 1'b1, 32'h600, 1'b1, 32'd10, 32'd6);
    ex_stall = 1'b1; tick(); tick();
    chk_res("pend.stall", 1'b1, 32'h600, 1'b1, 32'd10, 32'd6);
    idle(); tick();
    chk("pend.release", {31'd0, redirect_valid}, 32'd0);

    // Flush wins over a valid mispredicting branch
    drive(3'b000, 32'h40, 32'h100, 32'd7, 32'd7, 1'b0); ex_flush = 1'b1; tick(); idle();
    chk_res("flush", 1'b0, 32'h600, 1'b1, 32'd10, 32'd6);
    chk("flush.pred", {31'd0, if_pred_taken}, 32'd0);

    // Illegal funct3
    drive(3'b010, 32'h40, 32'h100, 32'd7, 32'd7, 1'b0); tick(); idle();
    chk("ill.pulse", {31'd0, illegal_br}, 32'd1);
    chk_res("ill", 1'b0, 32'h600, 1'b1, 32'd10, 32'd6);
    chk("ill.pred", {31'd0, if_pred_taken}, 32'd0);
    tick();
    chk("ill.end", {31'd0, illegal_br}, 32'd0);

    // Same-cycle lookup and update at 0x80
    if_pc = 32'h80;
    drive(3'b000, 32'h80, 32'h10, 32'd9, 32'd9, 1'b0); #1;
    chk("rbw.before", {31'd0, if_pred_taken}, 32'd0);
    tick(); idle();
    chk("rbw.after", {31'd0, if_pred_taken}, 32'd1);
    chk_res("rbw", 1'b1, 32'h90, 1'b1, 32'd11, 32'd7);

    // Target wrap-around
    drive(3'b000, 32'hFFFF_FFF0, 32'h20, 32'd1, 32'd1, 1'b1); tick(); idle();
    chk_res("wrap", 1'b0, 32'h10, 1'b1, 32'd12, 32'd7);

    // Reset in the same cycle as a mispredicting branch
    drive(3'b000, 32'h80, 32'h10, 32'd9, 32'd9, 1'b0); rst = 1'b1; tick(); idle(); rst = 1'b0;
    chk_res("midrst", 1'b0, 32'h0, 1'b0, 32'd0, 32'd0);
    chk("midrst.pred", {31'd0, if_pred_taken}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
